dsp_post_adder: RTL and testbench
=================================

DSP_POST_ADDER -- requirements
Module: dsp_post_adder

Interface
REQ-001 The block SHALL have parameter PREG, default 1, meaning 1 = P output registered and 0 = combinational.
REQ-002 The block SHALL have parameter CARRYOUTREG, default 1, meaning 1 = CARRYOUT registered and 0 = combinational.
REQ-003 The block SHALL have parameter OPMODEREG, default 1, meaning 1 = OPMODE registered and 0 = wire-through.
REQ-004 The block SHALL have parameter CARRYINREG, default 1, meaning 1 = selected carry-in registered and 0 = wire-through.
REQ-005 The block SHALL have parameter CARRYINSEL, default "OPMODE5", meaning carry-in source is "OPMODE5" (OPMODE[5]) or "CARRYIN" (CIN port).
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock, all state updating on the rising edge.
REQ-007 The block SHALL have port RSTP, input, 1 bit, reset, asynchronous and active-high, clearing every register in the block.
REQ-008 The block SHALL have port CEOPMODE, input, 1, OPMODE register enable.
REQ-009 The block SHALL have port CECARRYIN, input, 1, carry-in and carry-out register enable.
REQ-010 The block SHALL have port CEP, input, 1, P register enable.
REQ-011 The block SHALL have port OPMODE, input, 8, function select.
REQ-012 The block SHALL have port CIN, input, 1, external carry-in.
REQ-013 The block SHALL have port M, input, 36, multiplier product.
REQ-014 The block SHALL have port C, input, 48, C operand.
REQ-015 The block SHALL have port DAB, input, 48, concatenation {D[11:0],A[17:0],B[17:0]}.
REQ-016 The block SHALL have port PCIN, input, 48, cascade input.
REQ-017 The block SHALL have port P, output, 48, result.
REQ-018 The block SHALL have port PCOUT, output, 48, cascade output, identical to P.
REQ-019 The block SHALL have port CARRYOUT, output, 1, adder carry/borrow.
REQ-020 The block SHALL have port CARRYOUTF, output, 1, fabric copy of CARRYOUT.

Function
REQ-021 X mux on OPMODE[1:0]: 00 → 0; 01 → {12'b0,M}; 10 → P; 11 → DAB.
REQ-022 Z mux on OPMODE[3:2]: 00 → 0; 01 → PCIN; 10 → P; 11 → C.
REQ-023 OPMODE[7]=0: result = Z + X + CYI; OPMODE[7]=1: result = Z − (X + CYI); computed 49 bits wide, P = bits[47:0], carry = bit[48].
REQ-024 CYI = selected carry-in per CARRYINSEL, passed through the carry-in stage (registered when CARRYINREG=1).
REQ-025 OPMODE, when OPMODEREG=1, SHALL be captured at CLK edge when CEOPMODE=1; muxes use the registered value.
REQ-026 Latency with all parameters 1: OPMODE/CIN sampled at edge N, data sampled at edge N+1, P and CARRYOUT valid after edge N+1; each parameter set to 0 removes its stage.
REQ-027 CEP=0 SHALL hold P; CECARRYIN=0 SHALL hold both CYI and CARRYOUT registers.
REQ-028 X=P or Z=P (accumulate) SHALL use the current P register, so P(n+1) = P(n) ± operand, wrapping modulo 2^48.
REQ-029 X=P and Z=P together SHALL yield 2·P (add) or −CYI (subtract).
REQ-030 PREG=0 with P feedback selected is unsupported; simulation SHALL flag it with an assertion.
REQ-031 OPMODE[4] and OPMODE[6] SHALL be ignored by this block.

Reset
REQ-032 RSTP=1 SHALL immediately clear the OPMODE, CYI, P, and CARRYOUT registers to 0, independent of CLK and clock enables.
REQ-033 Reset SHALL take priority over all clock enables.
REQ-034 Reset asserted mid-accumulation SHALL cause accumulation to resume from P=0 on the first enabled edge after deassertion.

Structure
REQ-035 The shared package SHALL hold the OPMODE field constants (X/Z select codes, subtract bit, carry bit) and the width constants 36/48.
REQ-036 One sub-module, pipe_reg_async (parameter WIDTH, REG; asynchronous reset, clock enable), SHALL implement each optional stage.

Verification
REQ-037 Scenario "add": OPMODE=8'b0000_1101 (Z=C, X=M), C=100, M=25, CIN=0 → P=125, CARRYOUT=0 two edges after OPMODE.
REQ-038 Scenario "accumulate": OPMODE=8'b0000_1001 (Z=P, X=M), M=3, 4 enabled cycles from reset → P = 3, 6, 9, 12.
REQ-039 Scenario "subtract with borrow": OPMODE[7]=1, Z=C=5, X=DAB=7, CYI=0 → P=48'hFFFF_FFFF_FFFE; CARRYOUT is bit 48 of the 49-bit difference.
REQ-040 Scenario "carry-in and wrap": CARRYINSEL="OPMODE5", OPMODE[5]=1, Z=C=48'hFFFF_FFFF_FFFF, X=0 → P=0, CARRYOUT=1.
REQ-041 Scenario "enable/reset": CEP=0 holds P=12 across 3 edges; RSTP pulsed mid-cycle → P=0 before the next edge, then accumulation restarts at 3.

Source files
------------

// File: rtl/dsp_post_adder_pkg.sv
// dsp_post_adder_pkg: OPMODE field codes and datapath widths shared by the post-adder slice
package dsp_post_adder_pkg;
    localparam int M_W    = 36;
    localparam int P_W    = 48;
    localparam int OP_SUB = 7;
    localparam int OP_CY  = 5;
    typedef enum logic [1:0] {X_ZERO = 2'b00, X_M = 2'b01, X_P = 2'b10, X_DAB = 2'b11} x_sel_e;
    typedef enum logic [1:0] {Z_ZERO = 2'b00, Z_PCIN = 2'b01, Z_P = 2'b10, Z_C = 2'b11} z_sel_e;
    typedef struct packed {
        logic   sub;
        z_sel_e z;
        x_sel_e x;
    } opmode_t;
endpackage

// File: rtl/pipe_reg_async.sv
// pipe_reg_async: optional pipeline stage, a clock-enabled register with async clear or a plain wire
module pipe_reg_async #(
    parameter int WIDTH = 1,
    parameter bit REG   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    if (REG) begin : g_reg
        // capture D on enabled edges; reset clears regardless of CE
        always_ff @(posedge CLK or posedge RST)
            if (RST) Q <= '0;
            else if (CE) Q <= D;
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{CLK, RST, CE};
        assign Q = D;
    end
endmodule

// File: rtl/dsp_post_adder.sv
// dsp_post_adder: X/Z operand muxes feeding a 48-bit add/subtract with carry, optional pipeline stages
module dsp_post_adder
    import dsp_post_adder_pkg::*;
#(
    parameter bit    PREG        = 1,
    parameter bit    CARRYOUTREG = 1,
    parameter bit    OPMODEREG   = 1,
    parameter bit    CARRYINREG  = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic           CLK,
    input  logic           RSTP,
    input  logic           CEOPMODE,
    input  logic           CECARRYIN,
    input  logic           CEP,
    input  logic [7:0]     OPMODE,
    input  logic           CIN,
    input  logic [M_W-1:0] M,
    input  logic [P_W-1:0] C,
    input  logic [P_W-1:0] DAB,
    input  logic [P_W-1:0] PCIN,
    output logic [P_W-1:0] P,
    output logic [P_W-1:0] PCOUT,
    output logic           CARRYOUT,
    output logic           CARRYOUTF
);
    localparam bit USE_CIN = CARRYINSEL == "CARRYIN";
    opmode_t        op_q;
    logic           cyi;
    logic [P_W-1:0] x;
    logic [P_W-1:0] z;
    logic [P_W:0]   sum;
    logic           unused_op;
    // bits 4 and 6 belong to other slices of the DSP and have no effect here
    assign unused_op = ^{OPMODE[6], OPMODE[4]};
    pipe_reg_async #(.WIDTH(5), .REG(OPMODEREG)) u_opmode (
        .CLK(CLK), .RST(RSTP), .CE(CEOPMODE),
        .D({OPMODE[OP_SUB], OPMODE[3:0]}), .Q(op_q)
    );
    pipe_reg_async #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
        .CLK(CLK), .RST(RSTP), .CE(CECARRYIN),
        .D(USE_CIN ? CIN : OPMODE[OP_CY]), .Q(cyi)
    );
    // operand select and 49-bit add/subtract; bit 48 is the carry/borrow out
    always_comb begin
        x = op_q.x == X_M ? {{(P_W-M_W){1'b0}}, M} : op_q.x == X_P ? P : op_q.x == X_DAB ? DAB : '0;
        z = op_q.z == Z_PCIN ? PCIN : op_q.z == Z_P ? P : op_q.z == Z_C ? C : '0;
        sum = op_q.sub ? {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, cyi})
                       : {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cyi};
    end
    pipe_reg_async #(.WIDTH(P_W), .REG(PREG)) u_p (
        .CLK(CLK), .RST(RSTP), .CE(CEP), .D(sum[P_W-1:0]), .Q(P)
    );
    pipe_reg_async #(.WIDTH(1), .REG(CARRYOUTREG)) u_co (
        .CLK(CLK), .RST(RSTP), .CE(CECARRYIN), .D(sum[P_W]), .Q(CARRYOUT)
    );
    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;
    if (!PREG) begin : g_no_preg
        // P feedback without the P register would be a combinational loop
        always_comb
            assert (op_q.x != X_P && op_q.z != Z_P)
                else $error("dsp_post_adder: P feedback selected with PREG=0");
    end
endmodule

// File: tb/tb_dsp_post_adder.sv
// tb_dsp_post_adder: directed scenarios for dsp_post_adder with default parameters
module tb_dsp_post_adder;
    logic        CLK = 0;
    logic        RSTP = 0;
    logic        CEOPMODE = 1, CECARRYIN = 1, CEP = 1;
    logic [7:0]  OPMODE = '0;
    logic        CIN = 0;
    logic [35:0] M = '0;
    logic [47:0] C = '0, DAB = '0, PCIN = '0;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;
    int          checks = 0;
    int          errors = 0;

    dsp_post_adder dut (
        .CLK(CLK), .RSTP(RSTP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
        .OPMODE(OPMODE), .CIN(CIN), .M(M), .C(C), .DAB(DAB), .PCIN(PCIN),
        .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RSTP = 1;
        #2;
        RSTP = 0;
    endtask

    task automatic test_reset();
        OPMODE = 8'hFF; CIN = 1; M = '1; C = '1; DAB = '1; PCIN = '1;
        RSTP = 1;
        tick();
        tick();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL reset_p: got %h want %h", P, 48'd0); end
        checks++; if (PCOUT !== 48'd0) begin errors++; $display("FAIL reset_pcout: got %h want %h", PCOUT, 48'd0); end
        checks++; if ({CARRYOUT, CARRYOUTF} !== 2'b00) begin errors++; $display("FAIL reset_co: got %b want 00", {CARRYOUT, CARRYOUTF}); end
        RSTP = 0;
        OPMODE = '0; CIN = 0; M = '0; C = '0; DAB = '0; PCIN = '0;
        tick();
    endtask

    task automatic test_add();
        OPMODE = 8'b0000_1101; C = 48'd100; M = 36'd25; CIN = 0;
        tick();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL add_latency: got %0d want %0d", P, 0); end
        tick();
        checks++; if (P !== 48'd125) begin errors++; $display("FAIL add_p: got %0d want %0d", P, 125); end
        checks++; if (PCOUT !== 48'd125) begin errors++; $display("FAIL add_pcout: got %0d want %0d", PCOUT, 125); end
        checks++; if ({CARRYOUT, CARRYOUTF} !== 2'b00) begin errors++; $display("FAIL add_co: got %b want 00", {CARRYOUT, CARRYOUTF}); end
    endtask

    task automatic test_accumulate();
        pulse_reset();
        OPMODE = 8'b0000_1001; M = 36'd3;
        tick();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL acc_start: got %0d want %0d", P, 0); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (P !== 48'(3 * i)) begin errors++; $display("FAIL acc_step%0d: got %0d want %0d", i, P, 3 * i); end
        end
    endtask

    task automatic test_hold_reset();
        CEP = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (P !== 48'd12) begin errors++; $display("FAIL hold_p%0d: got %0d want %0d", i, P, 12); end
        end
        CEP = 1;
        #2;
        RSTP = 1;
        #1;
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL async_reset_p: got %0d want %0d", P, 0); end
        RSTP = 0;
        tick();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL restart_first: got %0d want %0d", P, 0); end
        tick();
        checks++; if (P !== 48'd3) begin errors++; $display("FAIL restart_second: got %0d want %0d", P, 3); end
    endtask

    task automatic test_subtract();
        pulse_reset();
        OPMODE = 8'b1000_1111; C = 48'd5; DAB = 48'd7; CIN = 0;
        tick();
        tick();
        checks++; if (P !== 48'hFFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_p: got %h want %h", P, 48'hFFFF_FFFF_FFFE); end
        checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL sub_co: got %b want %b", CARRYOUT, 1'b1); end
    endtask

    task automatic test_carry_wrap();
        OPMODE = 8'b0010_1100; C = 48'hFFFF_FFFF_FFFF;
        tick();
        tick();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL wrap_p: got %h want %h", P, 48'd0); end
        checks++; if (CARRYOUTF !== 1'b1) begin errors++; $display("FAIL wrap_co: got %b want %b", CARRYOUTF, 1'b1); end
    endtask

    task automatic test_ce_carry();
        CECARRYIN = 0;
        OPMODE = 8'b0000_1100; C = 48'd10;
        tick();
        tick();
        checks++; if (P !== 48'd11) begin errors++; $display("FAIL cyi_hold_p: got %0d want %0d", P, 11); end
        checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL co_hold: got %b want %b", CARRYOUT, 1'b1); end
        CECARRYIN = 1;
        tick();
        checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL co_release: got %b want %b", CARRYOUT, 1'b0); end
        tick();
        checks++; if (P !== 48'd10) begin errors++; $display("FAIL cyi_release_p: got %0d want %0d", P, 10); end
    endtask

    task automatic test_ignored_bits();
        OPMODE = 8'b0101_1101; C = 48'd100; M = 36'd25; CIN = 1;
        tick();
        tick();
        checks++; if (P !== 48'd125) begin errors++; $display("FAIL ignored_bits_p: got %0d want %0d", P, 125); end
        CIN = 0;
    endtask

    task automatic test_ceopmode();
        CEOPMODE = 0;
        OPMODE = 8'b0000_0000;
        tick();
        tick();
        checks++; if (P !== 48'd125) begin errors++; $display("FAIL opmode_hold: got %0d want %0d", P, 125); end
        CEOPMODE = 1;
    endtask

    task automatic test_double_p();
        OPMODE = 8'b0000_1010;
        tick();
        tick();
        checks++; if (P !== 48'd250) begin errors++; $display("FAIL double_p1: got %0d want %0d", P, 250); end
        tick();
        checks++; if (P !== 48'd500) begin errors++; $display("FAIL double_p2: got %0d want %0d", P, 500); end
        OPMODE = 8'b1010_1010;
        tick();
        tick();
        checks++; if (P !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL neg_cyi_p: got %h want %h", P, 48'hFFFF_FFFF_FFFF); end
        checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL neg_cyi_co: got %b want %b", CARRYOUT, 1'b1); end
    endtask

    task automatic test_back_to_back();
        OPMODE = 8'b0000_0100; PCIN = 48'h1234_5678_9ABC;
        tick();
        OPMODE = 8'b0000_0001; M = 36'hF_FFFF_FFFF;
        tick();
        checks++; if (P !== 48'h1234_5678_9ABC) begin errors++; $display("FAIL pcin_p: got %h want %h", P, 48'h1234_5678_9ABC); end
        tick();
        checks++; if (P !== 48'h000F_FFFF_FFFF) begin errors++; $display("FAIL m_zext_p: got %h want %h", P, 48'h000F_FFFF_FFFF); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_accumulate();
        test_hold_reset();
        test_subtract();
        test_carry_wrap();
        test_ce_carry();
        test_ignored_bits();
        test_ceopmode();
        test_double_p();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
